// File: rtl/pwm_sample_decoder_if.sv
// pwm_sample_decoder_if: groups the PWM line and the recovered-sample outputs.
// master drives the PWM line and consumes samples; slave is the decoder itself.
interface pwm_sample_decoder_if;
    logic       pwm_in;
    logic [7:0] sample_out;
    logic       sample_valid;
    logic       frame_err;
    logic       locked;

    modport master (
        output pwm_in,
        input  sample_out,
        input  sample_valid,
        input  frame_err,
        input  locked
    );

    modport slave (
        input  pwm_in,
        output sample_out,
        output sample_valid,
        output frame_err,
        output locked
    );
endinterface

// File: rtl/pwm_sample_decoder.sv
// pwm_sample_decoder: receive end of the sigout PWM stream.
// Measures high time and frame length of each PWM frame, emits one 8-bit
// sample per well-formed frame, treats a silent line as sample 0 and flags
// malformed frames / stuck-high lines.
// Optional feature macro: PWM_DEC_AVG_EN -- when defined, sample_out is the
// rounded 2-tap average of the previous and current accepted raw samples.
module pwm_sample_decoder #(
    parameter int PERIOD = 256,
    parameter int SLACK  = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    pwm_sample_decoder_if.slave  bus
);

    localparam int LIM = PERIOD + SLACK;
    localparam int CW  = $clog2(LIM) + 1;

    // A timeout fires on the cycle the frame counter would step onto LIM, so
    // a silent or stuck line produces one event every LIM cycles exactly.
    localparam logic [CW-1:0] TO_CNT = CW'(LIM - 1);
    localparam logic [CW-1:0] P_CNT  = CW'(PERIOD);
    localparam logic [CW-1:0] ONE    = CW'(1);
    localparam logic [CW-1:0] ZERO   = '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t        state;
    logic          s1, s, s_d;
    logic          rise, fall;
    logic [CW-1:0] hcnt, pcnt;
    logic          timeout;
    logic [7:0]    hsat;
    logic          frame_ok, tout_zero;
    logic [7:0]    take_val, zero_val;

    logic [7:0]    sample_q;
    logic          valid_q, err_q, locked_q;

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s1  <= 1'b0;
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s1  <= bus.pwm_in;
            s   <= s1;
            s_d <= s;
        end
    end

    assign rise    = s & ~s_d;
    assign fall    = ~s & s_d;
    assign timeout = (pcnt >= TO_CNT);

    // High time clamped to the 8-bit sample range.
    always_comb begin
        hsat = 8'd255;
        if (hcnt <= CW'(255)) hsat = 8'(hcnt);
    end

    // Accept / silence decisions shared by the FSM and the averaging register.
    assign frame_ok  = (state == LOW) && rise && (pcnt == P_CNT);
    assign tout_zero = (state != HIGH) && !rise && timeout;

`ifdef PWM_DEC_AVG_EN
    logic [7:0] prev;
    logic [8:0] sum_take, sum_zero;

    assign sum_take = {1'b0, prev} + {1'b0, hsat} + 9'd1;
    assign sum_zero = {1'b0, prev} + 9'd1;
    assign take_val = 8'(sum_take >> 1);
    assign zero_val = 8'(sum_zero >> 1);

    // Previous accepted raw sample; silent-line zeros count, bad frames don't.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            prev <= 8'd0;
        end else if (frame_ok) begin
            prev <= hsat;
        end else if (tout_zero) begin
            prev <= 8'd0;
        end
    end
`else
    assign take_val = hsat;
    assign zero_val = 8'd0;
`endif

    // Frame-measurement FSM with registered strobes and lock flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            hcnt     <= ZERO;
            pcnt     <= ZERO;
            sample_q <= 8'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= HIGH;
                        hcnt  <= ONE;
                        pcnt  <= ONE;
                    end else if (timeout) begin
                        // Still silent: another legal zero sample.
                        sample_q <= zero_val;
                        valid_q  <= 1'b1;
                        hcnt     <= ZERO;
                        pcnt     <= ZERO;
                    end else begin
                        pcnt <= pcnt + ONE;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state <= LOW;
                        pcnt  <= pcnt + ONE;
                    end else if (timeout) begin
                        // Line stuck high: report and restart measurement.
                        err_q    <= 1'b1;
                        locked_q <= 1'b0;
                        hcnt     <= ZERO;
                        pcnt     <= ZERO;
                    end else begin
                        hcnt <= hcnt + ONE;
                        pcnt <= pcnt + ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        if (pcnt == P_CNT) begin
                            sample_q <= take_val;
                            valid_q  <= 1'b1;
                            locked_q <= 1'b1;
                        end else begin
                            err_q    <= 1'b1;
                            locked_q <= 1'b0;
                        end
                        state <= HIGH;
                        hcnt  <= ONE;
                        pcnt  <= ONE;
                    end else if (timeout) begin
                        // No closing edge: line went silent, emit zero.
                        sample_q <= zero_val;
                        valid_q  <= 1'b1;
                        state    <= IDLE;
                        hcnt     <= ZERO;
                        pcnt     <= ZERO;
                    end else begin
                        pcnt <= pcnt + ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    hcnt  <= ZERO;
                    pcnt  <= ZERO;
                end
            endcase
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.frame_err    = err_q;
    assign bus.locked       = locked_q;

endmodule

// File: tb/tb_pwm_sample_decoder.sv
// tb_pwm_sample_decoder: directed PWM frames against a timestamp-based model
// of the decoder, checked every cycle, plus literal expectations per phase.
module tb_pwm_sample_decoder;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    pwm_sample_decoder_if bus();

    pwm_sample_decoder #(.PERIOD(256), .SLACK(4)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs after each rising edge.
    int   e_sample = 0;
    logic e_valid  = 1'b0;
    logic e_err    = 1'b0;
    logic e_locked = 1'b0;
    int   m_prev   = 0;

    function automatic int shape(input int cur);
        int r;
`ifdef PWM_DEC_AVG_EN
        r = (m_prev + cur + 1) / 2;
`else
        r = cur;
`endif
        m_prev = cur;
        return r;
    endfunction

    // Model: frame boundaries as cycle timestamps of the synchronized line.
    initial begin : model
        int cyc, t_start, t_fall, age, mode;
        logic m1, ms, msd, rise, fall, in_rst;
        cyc = 0; t_start = 0; t_fall = 0; mode = 0;
        m1 = 0; ms = 0; msd = 0; in_rst = 1;
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) begin
                mode = 0; m1 = 0; ms = 0; msd = 0; in_rst = 1;
                e_sample = 0; e_valid = 0; e_err = 0; e_locked = 0; m_prev = 0;
            end else begin
                cyc++;
                if (in_rst) begin t_start = cyc; in_rst = 0; end
                e_valid = 0; e_err = 0;
                rise = ms & ~msd;
                fall = ~ms & msd;
                age  = cyc - t_start;
                if (rise && mode != 1) begin
                    if (mode == 2) begin
                        if (age == 256) begin
                            e_sample = shape((t_fall - t_start > 255) ? 255 : t_fall - t_start);
                            e_valid  = 1; e_locked = 1;
                        end else begin
                            e_err = 1; e_locked = 0;
                        end
                    end
                    mode = 1; t_start = cyc;
                end else if (mode == 1) begin
                    if (fall) begin
                        mode = 2; t_fall = cyc;
                    end else if (age >= 259) begin
                        e_err = 1; e_locked = 0; t_start = cyc + 1;
                    end
                end else if (age >= 259) begin
                    e_sample = shape(0); e_valid = 1;
                    mode = 0; t_start = cyc + 1;
                end
                msd = ms; ms = m1; m1 = bus.pwm_in;
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            chk("sample_out", bus.sample_out, e_sample);
            chk("sample_valid", bus.sample_valid, e_valid);
            chk("frame_err", bus.frame_err, e_err);
            chk("locked", bus.locked, e_locked);
            chk("strobe_excl", bus.sample_valid & bus.frame_err, 0);
        end
    end

    // Strobe bookkeeping for phase-level literal checks.
    int nvalid = 0;
    int nerr   = 0;
    int sq[$];
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (bus.sample_valid) begin nvalid++; sq.push_back(int'(bus.sample_out)); end
            if (bus.frame_err) nerr++;
        end
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    task automatic drive(input logic v, input int n);
        repeat (n) begin
            bus.pwm_in = v;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input int hi, input int len);
        drive(1'b1, hi);
        drive(1'b0, len - hi);
    endtask

    task automatic clr();
        nvalid = 0;
        nerr   = 0;
        sq.delete();
    endtask

    initial begin : stim
        bus.pwm_in = 1'b0;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        chk("rst_sample", bus.sample_out, 0);
        chk("rst_locked", bus.locked, 0);
        clr();
        drive(1'b0, 4);
        chk("rst_quiet_strobes", nvalid + nerr, 0);

        // Steady 100/256 duty: first edge silent, then five samples of 100.
        clr();
        repeat (6) frame(100, 256);
        chk("steady_valids", nvalid, 5);
        chk("steady_errs", nerr, 0);
        chk("steady_sample", bus.sample_out, 100);
        chk("steady_locked", bus.locked, 1);

        // 200-cycle frames: the first edge closes a good frame, then errors.
        clr();
        repeat (5) frame(100, 200);
        chk("wrong_valids", nvalid, 1);
        chk("wrong_errs", nerr, 4);
        chk("wrong_held", bus.sample_out, 100);
        chk("wrong_locked", bus.locked, 0);

        // Relock.
        clr();
        repeat (6) frame(100, 256);
        chk("relock_errs", nerr, 1);
        chk("relock_valids", nvalid, 5);
        chk("relock_locked", bus.locked, 1);

        // Silence after lock: zeros every 260 cycles, lock kept.
        clr();
        drive(1'b0, 790);
        chk("silence_valids", nvalid, 4);
        chk("silence_errs", nerr, 0);
        chk("silence_sample", bus.sample_out, 0);
        chk("silence_locked", bus.locked, 1);

        // Stuck high: errors every 260 cycles, no samples.
        clr();
        drive(1'b1, 790);
        chk("stuck_errs", nerr, 3);
        chk("stuck_valids", nvalid, 0);
        chk("stuck_locked", bus.locked, 0);
        drive(1'b0, 20);

        // Reset in the middle of a locked frame.
        repeat (3) frame(100, 256);
        drive(1'b1, 50);
        chk("pre_rst_locked", bus.locked, 1);
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_rst_sample", bus.sample_out, 0);
        chk("async_rst_locked", bus.locked, 0);
        chk("async_rst_strobes", bus.sample_valid | bus.frame_err, 0);
        repeat (4) @(posedge clk);
        #1;
        n_rst = 1'b1;
        clr();
        drive(1'b1, 4);
        chk("post_rst_strobes", nvalid + nerr, 0);
        drive(1'b0, 20);

        // Sample sequence 50,100,200,255 then a silent zero, from reset.
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
        clr();
        frame(50, 256);
        frame(100, 256);
        frame(200, 256);
        frame(255, 256);
        drive(1'b1, 1);
        drive(1'b0, 300);
        chk("seq_count", sq.size(), 5);
        if (sq.size() == 5) begin
`ifdef PWM_DEC_AVG_EN
            chk("avg_0", sq[0], 25);
            chk("avg_1", sq[1], 75);
            chk("avg_100_200", sq[2], 150);
            chk("avg_3", sq[3], 228);
            chk("avg_255_0", sq[4], 128);
`else
            chk("raw_0", sq[0], 50);
            chk("raw_1", sq[1], 100);
            chk("raw_2", sq[2], 200);
            chk("raw_255", sq[3], 255);
            chk("raw_zero", sq[4], 0);
`endif
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_sample_decoder.md
# pwm_sample_decoder

Recovers 8-bit audio samples from the synthesizer's serial PWM output. It is the receive end of the `sigout` PWM stream. It sits in the loopback/self-test path and in the bench harness. It measures the high time and frame length of each PWM frame and emits one sample per valid frame with a one-cycle strobe. It also flags malformed frames, stuck-high lines and loss of lock.

## Interface
- `PERIOD`, default 256: expected PWM frame length in `clk` cycles (rising edge to rising edge).
- `SLACK`, default 4: extra cycles tolerated before a missing rising edge is treated as a timeout.
- `clk`, in, 1: system clock; all logic is on the rising edge.
- `n_rst`, in, 1: reset, asynchronous and active-low.
- `pwm_in`, in, 1: PWM line, asynchronous to `clk`.
- `sample_out`, out, 8: last recovered sample; held between strobes.
- `sample_valid`, out, 1: one-cycle pulse when `sample_out` is updated.
- `frame_err`, out, 1: one-cycle pulse on a malformed frame or a stuck-high line.
- `locked`, out, 1: level; high while frames are arriving well-formed.

## Operation
- **Input synchronizer:** `pwm_in` passes through a 2-flop synchronizer giving `s`. Edge detection is done on `s` against its registered copy.
- **Counters:**
  - `hcnt` and `pcnt` are each `$clog2(PERIOD+SLACK)+1` bits wide.
  - `hcnt` counts cycles with `s` high and saturates at 255 for output purposes.
  - `pcnt` counts every cycle of the current frame.
- **State machine:**
  - IDLE: after reset; wait for a rising edge on `s`. On that edge, go to HIGH with `hcnt`=1 and `pcnt`=1.
  - HIGH: increment both counters. A falling edge moves to LOW. If `pcnt` reaches `PERIOD+SLACK`, pulse `frame_err`, clear `locked`, stay in HIGH and clear both counters.
  - LOW: increment `pcnt`. A rising edge closes the frame; then:
    - If `pcnt`==`PERIOD`: load `sample_out`←`hcnt` (saturated), pulse `sample_valid`, set `locked`.
    - Otherwise: pulse `frame_err`, clear `locked`, leave `sample_out` unchanged.
    - In both cases, start a new frame in HIGH with `hcnt`=1 and `pcnt`=1.
  - IDLE/LOW timeout: if `pcnt` reaches `PERIOD+SLACK` without a rising edge, the line is silent and this is a legal sample 0.
    - `sample_out`←0 and pulse `sample_valid`; `locked` is unchanged.
    - Clear counters and go to IDLE, so a timeout repeats every `PERIOD+SLACK` cycles while the line stays low.
- **Simultaneous events:** a rising edge in the same cycle as a timeout is handled as a rising edge; the timeout is ignored.
- **Strobe exclusivity:** `sample_valid` and `frame_err` are never high in the same cycle.

## Timing
- **Reset values:** `sample_out`=0, `sample_valid`=0, `frame_err`=0, `locked`=0, state IDLE, counters 0, synchronizer flops 0.
- **Latency:** from a `pwm_in` pin rising edge to `sample_valid` is 3 `clk` cycles (2 synchronizer cycles plus 1 register cycle). Timeout strobes are registered the same way.
- **First sample:** the first frame after reset or IDLE never produces a sample. A sample requires a complete rising-to-rising frame.
- **Reset mid-frame:** asserting `n_rst` at any point discards the partial frame and returns all outputs to their reset values immediately.
- **Throughput:** at most one strobe per `PERIOD` cycles in normal operation.

## Configuration
- `PWM_DEC_AVG_EN` defined:
  - `sample_out` is a 2-tap average `(prev + cur + 1) >> 1`, computed in 9 bits. `prev` is the previously accepted raw sample.
  - Timeout zeros count as samples for averaging. Malformed frames do not.
  - `prev` resets to 0. Latency is unchanged.
- Undefined: `sample_out` is the raw measured `hcnt`, and there is no averaging register.

## Test plan
- **Reset:** hold `n_rst` low mid-stream. All outputs are 0 and the state is IDLE, with no strobe for 4 cycles after release.
- **Steady duty:** drive repeated 256-cycle frames, high for 100 cycles. The first edge gives no output. Each following frame gives `sample_valid` with `sample_out`=100 (raw) and `locked`=1.
- **Silence:** hold `pwm_in` low after lock. `sample_valid` with `sample_out`=0 occurs every 260 cycles, `locked` stays 1 and `frame_err` never fires.
- **Wrong period:** drive 200-cycle frames. `frame_err` pulses at each frame end, `locked`=0 and `sample_out` is held.
- **Stuck high:** hold `pwm_in` high. `frame_err` pulses every 260 cycles, there is no `sample_valid`, and `locked`=0.
- **Averaging (`PWM_DEC_AVG_EN`):** frames of 100 then 200. The second strobe gives `sample_out`=150; 255 then 0 gives 128.
